// File: rtl/sfilt_pkg.sv
// Shared definitions for the sfilt command sequencer: command codes,
// sequencer state encoding and the packed command bundle driven to sfilt.
package sfilt_pkg;

   localparam int DATA_W = 32;

   localparam logic [1:0] CMD_MULT  = 2'd0;
   localparam logic [1:0] CMD_MAC   = 2'd1;
   localparam logic [1:0] CMD_SHIFT = 2'd2;
   localparam logic [1:0] CMD_SEND  = 2'd3;

   // State names describe the command currently on the f_* outputs.
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_MULT  = 3'd1;
   localparam logic [2:0] ST_MAC   = 3'd2;
   localparam logic [2:0] ST_SHIFT = 3'd3;
   localparam logic [2:0] ST_SEND  = 3'd4;

   typedef struct packed {
      logic              push;
      logic [1:0]        cmd;
      logic [DATA_W-1:0] q;
      logic [DATA_W-1:0] h;
   } fcmd_t;

   // Build a valid command beat for the sfilt engine.
   function automatic fcmd_t mk_cmd(input logic [1:0] cmd,
                                    input logic [DATA_W-1:0] q,
                                    input logic [DATA_W-1:0] h);
      fcmd_t c;
      c.push = 1'b1;
      c.cmd  = cmd;
      c.q    = q;
      c.h    = h;
      return c;
   endfunction

endpackage

// File: rtl/sfilt_seq_dline.sv
// Circular sample buffer: registered write at the write pointer, which then
// advances modulo NTAPS; combinational read at any index.
module sfilt_seq_dline
   import sfilt_pkg::*;
#(
   parameter int NTAPS = 8,
   parameter int AW    = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic signed [DATA_W-1:0] wdata,
   output logic [AW-1:0]            wptr,
   input  logic [AW-1:0]            rd_addr,
   output logic signed [DATA_W-1:0] rd_data
);

   localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

   logic signed [DATA_W-1:0] mem [NTAPS];

   // Store the accepted sample and step the pointer, wrapping at NTAPS.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         for (int i = 0; i < NTAPS; i++) mem[i] <= '0;
      end else if (we) begin
         mem[wptr] <= wdata;
         wptr      <= (wptr == LAST) ? '0 : wptr + AW'(1);
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sfilt_seq.sv
// Command sequencer for the sfilt serial filter engine: takes one sample,
// streams MULT, NTAPS-1 MACs, SHIFT and SEND to sfilt one per cycle, and
// registers sfilt's results onto its own output.
module sfilt_seq
   import sfilt_pkg::*;
#(
   parameter int NTAPS = 8,
   parameter int SHIFT = 15
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     pushin,
   input  logic signed [DATA_W-1:0] din,
   output logic                     ready,
   input  logic                     cload,
   input  logic [4:0]               caddr,
   input  logic signed [DATA_W-1:0] cdata,
   output logic                     cerr,
   output logic                     f_push,
   output logic [1:0]               f_cmd,
   output logic [DATA_W-1:0]        f_q,
   output logic [DATA_W-1:0]        f_h,
   input  logic                     f_pushout,
   input  logic [DATA_W-1:0]        f_z,
   output logic                     pushout,
   output logic [DATA_W-1:0]        z
);

   localparam int              AW    = (NTAPS > 1) ? $clog2(NTAPS) : 1;
   localparam logic [5:0]      NT6   = 6'(NTAPS);
   localparam logic [AW-1:0]   NT_AW = AW'(NTAPS);
   localparam logic [6:0]      SH7   = 7'(SHIFT);

   logic [2:0]               state;
   logic [5:0]               k;
   logic [AW-1:0]            base;
   logic                     run;
   fcmd_t                    fo;
   logic                     accept;
   logic                     coef_we;
   logic [AW-1:0]            wptr;
   logic [AW-1:0]            rd_addr;
   logic [AW-1:0]            kk;
   logic signed [DATA_W-1:0] rd_data;
   logic signed [DATA_W-1:0] coef [NTAPS];

   assign ready   = run && (state == ST_IDLE);
   assign accept  = pushin && ready;
   assign coef_we = cload && (state == ST_IDLE) && !accept && ({1'b0, caddr} < NT6);

   sfilt_seq_dline #(
      .NTAPS (NTAPS),
      .AW    (AW)
   ) u_dline (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (accept),
      .wdata   (din),
      .wptr    (wptr),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // Tap address x[n-k] = (base - k) mod NTAPS; k < NTAPS whenever it is used,
   // so the AW-bit modular add is exact for both power-of-two and other sizes.
   always_comb begin
      kk = k[AW-1:0];
      if (base >= kk) rd_addr = base - kk;
      else            rd_addr = base + NT_AW - kk;
   end

   // Sequencer: each state names the command registered onto f_* this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         k     <= '0;
         base  <= '0;
         run   <= 1'b0;
         fo    <= '0;
      end else begin
         run <= 1'b1;
         fo  <= '0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state <= ST_MULT;
                  base  <= wptr;
                  k     <= 6'd1;
                  fo    <= mk_cmd(CMD_MULT, din, coef[0]);
               end
            end
            ST_MULT, ST_MAC: begin
               if (k < NT6) begin
                  state <= ST_MAC;
                  k     <= k + 6'd1;
                  fo    <= mk_cmd(CMD_MAC, rd_data, coef[kk]);
               end else begin
                  state <= ST_SHIFT;
                  fo    <= mk_cmd(CMD_SHIFT, '0, {25'd0, SH7});
               end
            end
            ST_SHIFT: begin
               state <= ST_SEND;
               fo    <= mk_cmd(CMD_SEND, '0, '0);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Coefficient table writes are only honoured while idle and in range.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NTAPS; i++) coef[i] <= '0;
      end else if (coef_we) begin
         coef[caddr[AW-1:0]] <= cdata;
      end
   end

   // Sticky flag for any dropped coefficient write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 cerr <= 1'b0;
      else if (cload && !coef_we) cerr <= 1'b1;
   end

   // Result stage: register sfilt's output, holding z between results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pushout <= 1'b0;
         z       <= '0;
      end else begin
         pushout <= f_pushout;
         if (f_pushout) z <= f_z;
      end
   end

   assign f_push = fo.push;
   assign f_cmd  = fo.cmd;
   assign f_q    = fo.q;
   assign f_h    = fo.h;

endmodule

// File: tb/tb_sfilt_seq.sv
// Bench for sfilt_seq: two instances (SHIFT=0 and SHIFT=1, NTAPS=4), each
// driving a behavioural sfilt engine; expected z values go into a queue.
module tb_sfilt_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pushin0 = 1'b0, pushin1 = 1'b0;
   logic        cload0 = 1'b0, cload1 = 1'b0;
   logic signed [31:0] din = '0;
   logic [4:0]  caddr = '0;
   logic signed [31:0] cdata = '0;

   logic        ready0, ready1, cerr0, cerr1;
   logic        f_push0, f_push1;
   logic [1:0]  f_cmd0, f_cmd1;
   logic [31:0] f_q0, f_q1, f_h0, f_h1;
   logic        f_pushout0, f_pushout1;
   logic [31:0] f_z0, f_z1;
   logic        pushout0, pushout1;
   logic [31:0] z0, z1;

   logic signed [63:0] acc0, acc1;
   logic [31:0] exp0[$];
   logic [31:0] exp1[$];
   logic [31:0] e0, e1;
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [1:0]  cmds [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};

   always #5 clk = ~clk;

   sfilt_seq #(.NTAPS(4), .SHIFT(0)) u0 (
      .clk(clk), .rst_n(rst_n), .pushin(pushin0), .din(din), .ready(ready0),
      .cload(cload0), .caddr(caddr), .cdata(cdata), .cerr(cerr0),
      .f_push(f_push0), .f_cmd(f_cmd0), .f_q(f_q0), .f_h(f_h0),
      .f_pushout(f_pushout0), .f_z(f_z0), .pushout(pushout0), .z(z0));

   sfilt_seq #(.NTAPS(4), .SHIFT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .pushin(pushin1), .din(din), .ready(ready1),
      .cload(cload1), .caddr(caddr), .cdata(cdata), .cerr(cerr1),
      .f_push(f_push1), .f_cmd(f_cmd1), .f_q(f_q1), .f_h(f_h1),
      .f_pushout(f_pushout1), .f_z(f_z1), .pushout(pushout1), .z(z1));

   // Behavioural sfilt: 64-bit accumulator, round-half-up right shift.
   function automatic logic signed [63:0] model_step(input logic signed [63:0] a,
                                                      input logic [1:0] cmd,
                                                      input logic [31:0] q,
                                                      input logic [31:0] h);
      logic signed [63:0] p;
      int s;
      p = $signed({{32{q[31]}}, q}) * $signed({{32{h[31]}}, h});
      s = int'(h[6:0]);
      case (cmd)
         2'd0:    return p;
         2'd1:    return a + p;
         2'd2:    return (s == 0) ? a : ((a + (64'sd1 <<< (s - 1))) >>> s);
         default: return a;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc0 <= '0; f_pushout0 <= 1'b0; f_z0 <= '0;
      end else begin
         f_pushout0 <= f_push0 && (f_cmd0 == 2'd3);
         if (f_push0 && f_cmd0 == 2'd3) f_z0 <= acc0[31:0];
         if (f_push0) acc0 <= model_step(acc0, f_cmd0, f_q0, f_h0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc1 <= '0; f_pushout1 <= 1'b0; f_z1 <= '0;
      end else begin
         f_pushout1 <= f_push1 && (f_cmd1 == 2'd3);
         if (f_push1 && f_cmd1 == 2'd3) f_z1 <= acc1[31:0];
         if (f_push1) acc1 <= model_step(acc1, f_cmd1, f_q1, f_h1);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   // Monitors: pop and compare whenever a result is presented.
   always @(negedge clk) begin
      if (rst_n && pushout0) begin
         if (exp0.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL z0_unexpected: got %0h, no result expected", z0);
         end else begin
            e0 = exp0.pop_front();
            chk("z0", z0, e0);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && pushout1) begin
         if (exp1.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL z1_unexpected: got %0h, no result expected", z1);
         end else begin
            e1 = exp1.pop_front();
            chk("z1", z1, e1);
         end
      end
   end

   task automatic wait_ready(input int inst);
      int c = 0;
      while (((inst == 0) ? ready0 : ready1) !== 1'b1 && c < 100) begin
         @(negedge clk);
         c++;
      end
      if (c >= 100) begin
         n_tests++; n_fail++;
         $display("FAIL ready_timeout: inst %0d got ready=0 required 1", inst);
      end
   endtask

   task automatic send0(input logic [31:0] v, input bit track, input logic [31:0] e);
      @(negedge clk);
      wait_ready(0);
      din = v; pushin0 = 1'b1;
      if (track) exp0.push_back(e);
      @(posedge clk); #1 pushin0 = 1'b0;
   endtask

   task automatic send1(input logic [31:0] v, input logic [31:0] e);
      @(negedge clk);
      wait_ready(1);
      din = v; pushin1 = 1'b1;
      exp1.push_back(e);
      @(posedge clk); #1 pushin1 = 1'b0;
   endtask

   task automatic load0(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      wait_ready(0);
      caddr = a; cdata = d; cload0 = 1'b1;
      @(posedge clk); #1 cload0 = 1'b0;
   endtask

   task automatic load1(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      wait_ready(1);
      caddr = a; cdata = d; cload1 = 1'b1;
      @(posedge clk); #1 cload1 = 1'b0;
   endtask

   task automatic drain();
      int c = 0;
      while ((exp0.size() != 0 || exp1.size() != 0) && c < 200) begin
         @(negedge clk);
         c++;
      end
      chk("drain_left0", exp0.size(), 0);
      chk("drain_left1", exp1.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", ready0, 0);
      chk("rst_f_push", f_push0, 0);
      chk("rst_f_cmd", f_cmd0, 0);
      chk("rst_f_q", f_q0, 0);
      chk("rst_f_h", f_h0, 0);
      chk("rst_pushout", pushout0, 0);
      chk("rst_z", z0, 0);
      chk("rst_cerr", cerr0, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_rst", ready0, 1);

      // Impulse through c={1,2,3,4}
      load0(0, 1); load0(1, 2); load0(2, 3); load0(3, 4);
      send0(1, 1, 1); send0(0, 1, 2); send0(0, 1, 3); send0(0, 1, 4);
      drain();

      // Command stream and ready timing for one sample
      @(negedge clk);
      wait_ready(0);
      din = 7; pushin0 = 1'b1; exp0.push_back(7);
      @(posedge clk); #1 pushin0 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("cmd%0d", i), {30'd0, f_cmd0}, {30'd0, cmds[i]});
         chk($sformatf("push%0d", i), f_push0, 1);
         chk($sformatf("busy%0d", i), ready0, 0);
         if (i == 0) begin
            chk("mult_q", f_q0, 7);
            chk("mult_h", f_h0, 1);
         end
         if (i == 1) begin
            chk("mac1_q", f_q0, 0);
            chk("mac1_h", f_h0, 2);
         end
         if (i == 5) chk("send_h", f_h0, 0);
      end
      @(negedge clk);
      chk("push_end", f_push0, 0);
      chk("ready_end", ready0, 1);
      drain();

      // Rounding (SHIFT=1) and negative result (SHIFT=0)
      load1(0, 3);
      send1(1, 2);
      load0(0, 2); load0(1, 0); load0(2, 0); load0(3, 0);
      send0(-5, 1, 32'hFFFFFFF6);
      drain();

      // Dropped coefficient writes
      chk("cerr_clean", cerr0, 0);
      send0(1, 1, 2);
      @(posedge clk); #1;
      caddr = 5'd1; cdata = 99; cload0 = 1'b1;
      @(posedge clk); #1 cload0 = 1'b0;
      chk("cerr_mac", cerr0, 1);
      load0(5'd7, 55);
      chk("cerr_range", cerr0, 1);
      chk("cerr_other_inst", cerr1, 0);
      send0(0, 1, 0); send0(0, 1, 0); send0(0, 1, 0);
      drain();
      chk("cerr_sticky", cerr0, 1);

      // pushin held high: every sample accepted exactly once
      load0(0, 1);
      for (int v = 1; v <= 5; v++) begin
         @(negedge clk);
         wait_ready(0);
         din = v; pushin0 = 1'b1;
         exp0.push_back(v);
         @(posedge clk);
      end
      @(negedge clk);
      pushin0 = 1'b0;
      drain();

      // Reset during MAC, then clean impulse response
      load0(0, 1); load0(1, 2); load0(2, 3); load0(3, 4);
      send0(9, 0, 0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("abort_push", f_push0, 0);
      chk("abort_ready", ready0, 0);
      chk("abort_cerr", cerr0, 0);
      chk("abort_z", z0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      load0(0, 1); load0(1, 2); load0(2, 3); load0(3, 4);
      send0(1, 1, 1); send0(0, 1, 2); send0(0, 1, 3); send0(0, 1, 4);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
